cla_16bit_with_lcu: RTL and testbench



---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla_16bit_with_lcu_if.sv | 17 +
 rtl/cla_16bit_with_lcu_cla_4bit.sv | 33 +++
 rtl/cla_16bit_with_lcu.sv | 86 ++++++++
 tb/tb_cla_16bit_with_lcu.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the 16-bit two-level carry-lookahead adder.
// Optional input register stage is controlled by CLA_INPUT_REG_EN in the top.
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_BLOCK = 4;
    localparam int CLA_NBLK  = 4;

    typedef logic [CLA_WIDTH-1:0] operand_t;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Group propagate/generate of four ordered (p,g) pairs, index 3 most significant.
    function automatic pg_t group_pg(input logic [3:0] p_in, input logic [3:0] g_in);
        pg_t res;
        res.p = p_in[3] & p_in[2] & p_in[1] & p_in[0];
        res.g = g_in[3]
              | (p_in[3] & g_in[2])
              | (p_in[3] & p_in[2] & g_in[1])
              | (p_in[3] & p_in[2] & p_in[1] & g_in[0]);
        return res;
    endfunction

endpackage

// File: rtl/cla_16bit_with_lcu_if.sv
// Operand/result bundle of the 16-bit CLA; master drives operands, slave returns results.
interface cla_16bit_with_lcu_if;
    import cla_pkg::*;

    operand_t in1;
    operand_t in2;
    logic     c_in;
    operand_t sum;
    logic     c_out;
    logic     p;
    logic     g;

    modport master (output in1, output in2, output c_in,
                    input  sum, input  c_out, input  p, input  g);
    modport slave  (input  in1, input  in2, input  c_in,
                    output sum, output c_out, output p, output g);
endinterface

// File: rtl/cla_16bit_with_lcu_cla_4bit.sv
// 4-bit carry-lookahead block with fully expanded internal carries and block P/G.
module cla_4bit
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       P,
    output logic       G
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [3:0] c_s;
    pg_t        blk_s;

    // Bit propagate/generate and two-level carries; no carry depends on another carry.
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        s      = p_s ^ c_s;
        blk_s  = group_pg(p_s, g_s);
        P      = blk_s.p;
        G      = blk_s.g;
    end

endmodule

// File: rtl/cla_16bit_with_lcu.sv
// 16-bit adder: four cla_4bit blocks, a lookahead carry unit and a registered result.
// Defining CLA_INPUT_REG_EN adds an operand register, giving 2-cycle latency.
module cla_16bit_with_lcu
    import cla_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cla_16bit_with_lcu_if.slave  bus
);

    operand_t            a_s;
    operand_t            b_s;
    logic                cin_s;
    operand_t            sum_s;
    logic [CLA_NBLK-1:0] blk_p_s;
    logic [CLA_NBLK-1:0] blk_g_s;
    logic [CLA_NBLK:0]   c_s;
    pg_t                 grp_s;

`ifdef CLA_INPUT_REG_EN
    operand_t a_r;
    operand_t b_r;
    logic     cin_r;

    // Operand capture stage; cleared by reset so no stale operation survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= 16'h0000;
            b_r   <= 16'h0000;
            cin_r <= 1'b0;
        end else begin
            a_r   <= bus.in1;
            b_r   <= bus.in2;
            cin_r <= bus.c_in;
        end
    end

    assign a_s   = a_r;
    assign b_s   = b_r;
    assign cin_s = cin_r;
`else
    assign a_s   = bus.in1;
    assign b_s   = bus.in2;
    assign cin_s = bus.c_in;
`endif

    for (genvar k = 0; k < CLA_NBLK; k++) begin : g_blk
        cla_4bit u_blk (
            .a   (a_s[k*CLA_BLOCK +: CLA_BLOCK]),
            .b   (b_s[k*CLA_BLOCK +: CLA_BLOCK]),
            .cin (c_s[k]),
            .s   (sum_s[k*CLA_BLOCK +: CLA_BLOCK]),
            .P   (blk_p_s[k]),
            .G   (blk_g_s[k])
        );
    end

    // Lookahead carry unit: every block carry-in is a flat sum of products of block P/G.
    always_comb begin
        c_s[0] = cin_s;
        c_s[1] = blk_g_s[0] | (blk_p_s[0] & cin_s);
        c_s[2] = blk_g_s[1] | (blk_p_s[1] & blk_g_s[0]) | (blk_p_s[1] & blk_p_s[0] & cin_s);
        c_s[3] = blk_g_s[2] | (blk_p_s[2] & blk_g_s[1]) | (blk_p_s[2] & blk_p_s[1] & blk_g_s[0])
               | (blk_p_s[2] & blk_p_s[1] & blk_p_s[0] & cin_s);
        c_s[4] = blk_g_s[3] | (blk_p_s[3] & blk_g_s[2]) | (blk_p_s[3] & blk_p_s[2] & blk_g_s[1])
               | (blk_p_s[3] & blk_p_s[2] & blk_p_s[1] & blk_g_s[0])
               | (blk_p_s[3] & blk_p_s[2] & blk_p_s[1] & blk_p_s[0] & cin_s);
        grp_s  = group_pg(blk_p_s, blk_g_s);
    end

    // Result register; asynchronous reset drops any in-flight result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum   <= 16'h0000;
            bus.c_out <= 1'b0;
            bus.p     <= 1'b0;
            bus.g     <= 1'b0;
        end else begin
            bus.sum   <= sum_s;
            bus.c_out <= c_s[4];
            bus.p     <= grp_s.p;
            bus.g     <= grp_s.g;
        end
    end

endmodule

// File: tb/tb_cla_16bit_with_lcu.sv
// Self-checking bench for cla_16bit_with_lcu: directed table, async reset sequence, random run.
module tb_cla_16bit_with_lcu;
    import cla_pkg::*;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] sum;
        logic        co;
        logic        p;
        logic        g;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        p;
        logic        g;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cla_16bit_with_lcu_if bus ();

    cla_16bit_with_lcu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: plain 17-bit addition, p from xor, g as carry-out with no carry-in.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        res_t        r;
        logic [16:0] full;
        logic [16:0] nocin;
        full  = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
        nocin = {1'b0, a} + {1'b0, b};
        r.sum = full[15:0];
        r.co  = full[16];
        r.p   = &(a ^ b);
        r.g   = nocin[16];
        return r;
    endfunction

    task automatic check_out(input string name, input logic [15:0] sum, input logic co,
                             input logic p, input logic g);
        checks++;
        if (bus.sum !== sum || bus.c_out !== co || bus.p !== p || bus.g !== g) begin
            failures++;
            $display("FAIL %s: got sum=%h c_out=%b p=%b g=%b, expected sum=%h c_out=%b p=%b g=%b",
                     name, bus.sum, bus.c_out, bus.p, bus.g, sum, co, p, g);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci);
        bus.in1  = a;
        bus.in2  = b;
        bus.c_in = ci;
    endtask

    vec_t   tbl[10];
    res_t   exp_q[$];
    res_t   e;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    initial begin
        checks   = 0;
        failures = 0;
        tbl[0] = '{16'd3245,  16'd16785, 1'b0, 16'd20030, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'd3245,  16'd16785, 1'b1, 16'd20031, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'd25000, 16'd40535, 1'b0, 16'd65535, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'd25001, 16'd40535, 1'b0, 16'd0,     1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0000,  16'h0000,  1'b0, 16'h0000,  1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h0000,  16'h0000,  1'b1, 16'h0001,  1'b0, 1'b0, 1'b0};
        tbl[8] = '{16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1, 1'b0, 1'b1};
        tbl[9] = '{16'h0F0F,  16'hF0F0,  1'b1, 16'h0000,  1'b1, 1'b1, 1'b0};

        // Reset state, held across clock edges with live operands.
        rst = 1'b1;
        drive(16'h1234, 16'h4321, 1'b1);
        repeat (3) @(posedge clk);
        #1 check_out("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        // Directed table; p/g for the first two rows come from the arithmetic model.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].b, tbl[i].ci);
            if (i < 2) begin
                e = model(tbl[i].a, tbl[i].b, tbl[i].ci);
                tbl[i].p = e.p;
                tbl[i].g = e.g;
            end
            repeat (LAT) @(posedge clk);
            #1 check_out($sformatf("vec%0d", i), tbl[i].sum, tbl[i].co, tbl[i].p, tbl[i].g);
        end

        // Asynchronous reset between edges while a nonzero result is held.
        @(negedge clk);
        drive(16'h1111, 16'h2222, 1'b1);
        repeat (LAT) @(posedge clk);
        #1 check_out("pre_reset", 16'h3334, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_out("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(16'hFFFF, 16'h0000, 1'b1);
        repeat (LAT) @(posedge clk);
        #1 check_out("after_reset", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Back-to-back random operations against the arithmetic model.
        exp_q.delete();
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if (exp_q.size() == LAT) begin
                e = exp_q.pop_front();
                check_out("random", e.sum, e.co, e.p, e.g);
                checks++;
                if (bus.p === 1'b1 && bus.g === 1'b1) begin
                    failures++;
                    $display("FAIL pg_exclusive: got p=%b g=%b, expected not both 1", bus.p, bus.g);
                end
            end
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ~ra : 16'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc);
            exp_q.push_back(model(ra, rb, rc));
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
